// File: rtl/register_bank.sv
// Two-read, one-write register file with register 0 hardwired to zero.
// Contents clear asynchronously while Rst is low; reads are purely combinational.
module register_bank #(
  parameter int n_addr = 5,
  parameter int n_reg  = 2 ** n_addr,
  parameter int n_bit  = 2 ** n_addr
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [n_addr-1:0] Rd_reg_1,
  input  logic [n_addr-1:0] Rd_reg_2,
  input  logic [n_addr-1:0] Wr_reg,
  input  logic [n_bit-1:0]  Wr_data,
  output logic [n_bit-1:0]  Rd_data_1,
  output logic [n_bit-1:0]  Rd_data_2,
  input  logic              Reg_write
);

  logic [n_bit-1:0] regs [n_reg];

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < n_reg; i++) begin
        regs[i] <= '0;
      end
    end else if (Reg_write && (Wr_reg != '0)) begin
      regs[Wr_reg] <= Wr_data;
    end
  end

  // No write-through bypass: a same-cycle read sees the old value until the edge
  always_comb begin
    Rd_data_1 = '0;
    Rd_data_2 = '0;
    if (Rst && (Rd_reg_1 != '0)) begin
      Rd_data_1 = regs[Rd_reg_1];
    end
    if (Rst && (Rd_reg_2 != '0)) begin
      Rd_data_2 = regs[Rd_reg_2];
    end
  end

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank: directed literal checks plus
// randomized traffic compared every cycle against an array-based model.
module tb_register_bank;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [4:0]  Rd_reg_1 = '0;
  logic [4:0]  Rd_reg_2 = '0;
  logic [4:0]  Wr_reg = '0;
  logic [31:0] Wr_data = '0;
  logic [31:0] Rd_data_1;
  logic [31:0] Rd_data_2;
  logic        Reg_write = 1'b0;

  int total = 0;
  int bad = 0;

  logic [31:0] model [32];

  register_bank dut (
    .Clk(Clk),
    .Rst(Rst),
    .Rd_reg_1(Rd_reg_1),
    .Rd_reg_2(Rd_reg_2),
    .Wr_reg(Wr_reg),
    .Wr_data(Wr_data),
    .Rd_data_1(Rd_data_1),
    .Rd_data_2(Rd_data_2),
    .Reg_write(Reg_write)
  );

  always #5 Clk = ~Clk;

  // Reference storage: plain array, cleared whenever reset falls
  always @(negedge Rst) begin
    for (int i = 0; i < 32; i++) model[i] = '0;
  end

  always @(posedge Clk) begin
    if (Rst && Reg_write && Wr_reg != 5'd0) model[Wr_reg] = Wr_data;
  end

  function automatic logic [31:0] expectRead(input logic [4:0] addr);
    if (!Rst || addr == 5'd0) return 32'h0;
    return model[addr];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               input logic [4:0] r1, input logic [4:0] r2);
    @(posedge Clk);
    #1;
    Reg_write = we;
    Wr_reg    = wa;
    Wr_data   = wd;
    Rd_reg_1  = r1;
    Rd_reg_2  = r2;
  endtask

  // Continuous comparison against the model on every falling edge
  always @(negedge Clk) begin
    checkOutput("port1_model", Rd_data_1, expectRead(Rd_reg_1));
    checkOutput("port2_model", Rd_data_2, expectRead(Rd_reg_2));
  end

  initial begin
    for (int i = 0; i < 32; i++) model[i] = '0;
    #1 Rst = 1'b0;

    // Every address reads zero while reset is held and after release
    for (int a = 0; a < 32; a++) begin
      applyStimulus(1'b1, 5'(a), 32'hDEAD_BEEF, 5'(a), 5'(31 - a));
      #1;
      checkOutput("reset_hold_p1", Rd_data_1, 32'h0);
      checkOutput("reset_hold_p2", Rd_data_2, 32'h0);
    end
    @(posedge Clk);
    #2 Rst = 1'b1;
    Reg_write = 1'b0;
    for (int a = 0; a < 32; a++) begin
      applyStimulus(1'b0, 5'd0, 32'h0, 5'(a), 5'(31 - a));
      #1;
      checkOutput("reset_rel_p1", Rd_data_1, 32'h0);
      checkOutput("reset_rel_p2", Rd_data_2, 32'h0);
    end

    // Two writes on consecutive edges, then read both back
    applyStimulus(1'b1, 5'd9, 32'h0002_453E, 5'd0, 5'd0);
    applyStimulus(1'b1, 5'd3, 32'h0003_423F, 5'd0, 5'd0);
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd9, 5'd3);
    #1;
    checkOutput("write_r9", Rd_data_1, 32'h0002_453E);
    checkOutput("write_r3", Rd_data_2, 32'h0003_423F);

    // Register 0 ignores writes
    applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd9);
    #1;
    checkOutput("r0_zero", Rd_data_1, 32'h0);
    checkOutput("r0_neighbour", Rd_data_2, 32'h0002_453E);

    // Disabled write leaves register 9 untouched
    applyStimulus(1'b0, 5'd9, 32'h1234_5678, 5'd9, 5'd3);
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd9, 5'd3);
    #1;
    checkOutput("we_off_r9", Rd_data_1, 32'h0002_453E);

    // Same-cycle read/write of register 5: old value, then new value
    applyStimulus(1'b1, 5'd5, 32'hA5A5_A5A5, 5'd5, 5'd5);
    #1;
    checkOutput("rw_before", Rd_data_1, 32'h0);
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    #1;
    checkOutput("rw_after_p1", Rd_data_1, 32'hA5A5_A5A5);
    checkOutput("rw_after_p2", Rd_data_2, 32'hA5A5_A5A5);

    // Reset pulse between edges clears contents immediately
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd9, 5'd3);
    #1 Rst = 1'b0;
    #1;
    checkOutput("midrst_r9", Rd_data_1, 32'h0);
    checkOutput("midrst_r3", Rd_data_2, 32'h0);
    Rst = 1'b1;
    #1;
    checkOutput("postrst_r9", Rd_data_1, 32'h0);
    checkOutput("postrst_r3", Rd_data_2, 32'h0);

    // Randomized traffic with mid-cycle glitches and occasional reset pulses
    for (int n = 0; n < 600; n++) begin
      @(posedge Clk);
      #1;
      Reg_write = 1'($urandom);
      Wr_reg    = 5'($urandom);
      Wr_data   = $urandom;
      #1;
      Reg_write = ($urandom_range(0, 3) != 0);
      Wr_reg    = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      Wr_data   = $urandom;
      Rd_reg_1  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      Rd_reg_2  = 5'($urandom);
      if ($urandom_range(0, 49) == 0) begin
        #1 Rst = 1'b0;
        #1 Rst = 1'b1;
      end
    end

    @(posedge Clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
